ledstrip_glyph_scroller: RTL and testbench
==========================================

// Module: ledstrip_glyph_scroller
// PURPOSE
//  Sits directly downstream of the ledstrip character ROM. Accepts one ASCII code per handshake, drives it onto the
//  ROM address bus, captures the returned 35-bit 5x7 glyph, then emits the glyph one 7-bit column at a time to
//  the LED-strip pixel driver over a valid/ready handshake. The column stream is what scrolls across the strip.
// PARAMETERS
//  ROWS    7   pixel rows per glyph (column word width)
//  COLS    5   columns per glyph
//  ADDR_W  7   ROM address / character code width
//  GLYPH_W ROWS*COLS  ROM data width (localparam, not overridable)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  char_in    in   ADDR_W   ASCII code to render
//  char_valid in   1        char_in valid
//  char_ready out  1        scroller can accept a character
//  rom_addr   out  ADDR_W   address to character ROM (combinational ROM, same-cycle data)
//  rom_data   in   GLYPH_W  glyph bits from ROM; bit (col*ROWS + row), col 0 = leftmost, row 0 = top
//  col_data   out  ROWS     current column pixels, bit r = row r lit
//  col_valid  out  1        col_data valid
//  col_ready  in   1        pixel driver consumes column this cycle
//  busy       out  1        high while any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, char_ready=1, col_valid=0, col_data=0, rom_addr=0, busy=0, glyph reg=0, col_cnt=0.
//  - FSM: IDLE -> FETCH -> SHIFT [-> GAP] -> IDLE.
//  - IDLE: char_ready=1. On char_valid&&char_ready, register char_in into char_q; next state FETCH.
//  - FETCH: 1 cycle. rom_addr = char_q (rom_addr is always driven from char_q). Latch rom_data into glyph reg,
//    col_cnt=0; next SHIFT. Codes <32 pass through unchanged (ROM returns all-ones glyph); no filtering here.
//  - SHIFT: col_valid=1, col_data=glyph[col_cnt*ROWS +: ROWS]. col_data stays stable while col_valid&&!col_ready.
//    On col_valid&&col_ready: if col_cnt==COLS-1, go to GAP (macro defined) or IDLE; else col_cnt++.
//  - Latency: char accepted at edge N -> FETCH cycle N+1 -> first col_valid in cycle N+2. Column throughput is
//    1 per cycle when col_ready is held at 1.
//  - char_ready=0 in FETCH/SHIFT/GAP; no overlap with the next character. char_valid in those states is ignored
//    and char_in is not sampled.
//  - col_cnt width = $clog2(COLS); it never exceeds COLS-1, and no wrap is permitted.
//  - rst_n asserted mid-glyph: immediate abort to reset values. The pending column is dropped. No partial
//    glyph resumes after reset.
//  - Back-to-back: earliest re-accept is the cycle after the last column (or gap) handshake. With col_ready=1,
//    the minimum period is COLS+2 cycles per character (COLS+3 with gap).
// CONFIGURATION
//  LEDSTRIP_SCROLL_GAP_EN:
//    defined -> after the last glyph column, GAP state emits one blank column (col_data=0, col_valid=1) with the
//               same handshake, then returns to IDLE.
//    undefined -> no GAP state; SHIFT goes straight to IDLE and glyphs abut on the strip.
// STRUCTURE
//  - Shared package ledstrip_pkg: state enum (IDLE, FETCH, SHIFT, GAP) and constants LS_ROWS=7, LS_COLS=5,
//    LS_ADDR_W=7. The same package is used by the pixel driver.
//  - Single module; the ROM is instantiated by the parent, not inside this block. The column mux is inline;
//    no sub-module is warranted.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs -> char_ready=1, col_valid=0, col_data=0, busy=0. Release: no
//     column appears.
//  2. 'A' (0x41), col_ready=1, ROM model: rom_addr=0x41 in FETCH. Five columns, equal to ROM bits [6:0], [13:7],
//     ..., [34:28], appear on consecutive cycles starting at N+2.
//  3. Backpressure: during col 2, col_ready=0 for 4 cycles -> col_data/col_valid frozen. Column resumes on the
//     first ready cycle and no column is skipped or repeated.
//  4. Ignore while busy: pulse char_valid with 0x42 during SHIFT -> char_ready=0, the 0x42 glyph is never emitted,
//     and the 0x41 columns are intact.
//  5. Control code 0x05 -> five columns of 7'h7F. With LEDSTRIP_SCROLL_GAP_EN, a 6th column of 7'h00 is emitted;
//     without the macro, busy drops after column 5.
//  6. rst_n pulsed during col 3 -> outputs take reset values asynchronously, and the next char starts at col 0.

Source files
------------

// File: rtl/ledstrip_pkg.sv
// Shared ledstrip types and constants.
// Used by the glyph scroller and the pixel driver.
package ledstrip_pkg;

    localparam int LS_ROWS   = 7;
    localparam int LS_COLS   = 5;
    localparam int LS_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        GAP
    } ls_state_t;

endpackage

// File: rtl/ledstrip_glyph_scroller.sv
// Fetches a 5x7 glyph from the char ROM and streams it out column by column.
// Define LEDSTRIP_SCROLL_GAP_EN to append one blank column after each glyph.
module ledstrip_glyph_scroller
    import ledstrip_pkg::*;
#(
    parameter int ROWS   = LS_ROWS,
    parameter int COLS   = LS_COLS,
    parameter int ADDR_W = LS_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      char_in,
    input  logic                   char_valid,
    output logic                   char_ready,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [ROWS*COLS-1:0]   rom_data,
    output logic [ROWS-1:0]        col_data,
    output logic                   col_valid,
    input  logic                   col_ready,
    output logic                   busy
);

    localparam int GLYPH_W = ROWS * COLS;
    localparam int CNT_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COLS - 1);

    ls_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    char_q;
    logic [GLYPH_W-1:0]   glyph_q;
    logic [CNT_W-1:0]     col_cnt;
    logic                 last;

    assign last     = (col_cnt == LAST);
    assign rom_addr = char_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            char_q  <= '0;
            glyph_q <= '0;
            col_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && char_valid)
                char_q <= char_in;
            if (state_q == FETCH) begin
                glyph_q <= rom_data;
                col_cnt <= '0;
            end
            if (state_q == SHIFT && col_ready && !last)
                col_cnt <= col_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        char_ready = 1'b0;
        col_valid  = 1'b0;
        col_data   = '0;
        unique case (state_q)
            IDLE: begin
                char_ready = 1'b1;
                if (char_valid)
                    state_d = FETCH;
            end
            FETCH: state_d = SHIFT;
            SHIFT: begin
                col_valid = 1'b1;
                col_data  = glyph_q[ROWS*int'(col_cnt) +: ROWS];
                if (col_ready && last) begin
`ifdef LEDSTRIP_SCROLL_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
            GAP: begin
                // Blank spacer column between glyphs
                col_valid = 1'b1;
                if (col_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ledstrip_glyph_scroller.sv
// Directed bench for ledstrip_glyph_scroller with a column scoreboard.
// Honours LEDSTRIP_SCROLL_GAP_EN for the expected blank column.
module tb_ledstrip_glyph_scroller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [6:0]  rom_addr;
    logic [34:0] rom_data;
    logic [6:0]  col_data;
    logic        col_valid;
    logic        col_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [6:0] q[$];

    always #5 clk = ~clk;

    function automatic logic [34:0] rom(input logic [6:0] a);
        if (a < 7'd32)
            return '1;
        return {a ^ 7'h2A, a + 7'd3, a ^ 7'h55, ~a, a};
    endfunction

    assign rom_data = rom(rom_addr);

    ledstrip_glyph_scroller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on every column handshake (sampled mid-cycle)
    always @(negedge clk) begin
        if (rst_n && col_valid && col_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_col", {25'd0, col_data}, 32'hFFFF_FFFF);
            end else begin
                chk("col_data", {25'd0, col_data}, {25'd0, q[0]});
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_glyph(input logic [6:0] code);
        logic [34:0] g;
        g = rom(code);
        for (int c = 0; c < 5; c++)
            q.push_back(g[c*7 +: 7]);
`ifdef LEDSTRIP_SCROLL_GAP_EN
        q.push_back(7'h00);
`endif
    endtask

    // Accept a char; returns positioned in the FETCH cycle
    task automatic send(input logic [6:0] code);
        push_glyph(code);
        char_in    = code;
        char_valid = 1'b1;
        chk("ready_idle", 32'(char_ready), 32'd1);
        step();
        char_valid = 1'b0;
        chk("fetch_addr", 32'(rom_addr), 32'(code));
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_nrdy", 32'(char_ready), 32'd0);
        chk("fetch_nval", 32'(col_valid), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy)
                break;
            step();
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    logic [6:0] hold;
    logic       exp_busy;

    initial begin
        rst_n      = 1'b0;
        char_in    = '0;
        char_valid = 1'b0;
        col_ready  = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            char_in    = 7'($urandom);
            char_valid = 1'($urandom);
            col_ready  = 1'($urandom);
            step();
            chk("rst_ready", 32'(char_ready), 32'd1);
            chk("rst_valid", 32'(col_valid), 32'd0);
            chk("rst_data", 32'(col_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_addr", 32'(rom_addr), 32'd0);
        char_valid = 1'b0;
        col_ready  = 1'b1;
        rst_n      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", 32'(col_valid), 32'd0);
        end

        // 2: 'A' streamed at full rate, first column at N+2
        send(7'h41);
        step();
        chk("lat_valid", 32'(col_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("thru_valid", 32'(col_valid), 32'd1);
        end
        wait_idle();

        // 3: backpressure during column 2
        send(7'h41);
        step();
        step();
        step();
        hold = q[0];
        col_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", 32'(col_valid), 32'd1);
            chk("bp_data", 32'(col_data), 32'(hold));
        end
        col_ready = 1'b1;
        wait_idle();

        // 4: char offered while busy is ignored
        send(7'h41);
        step();
        char_in    = 7'h42;
        char_valid = 1'b1;
        chk("busy_nrdy", 32'(char_ready), 32'd0);
        step();
        char_valid = 1'b0;
        wait_idle();

        // 5: control code gives all-ones glyph
        send(7'h05);
        for (int i = 0; i < 6; i++)
            step();
`ifdef LEDSTRIP_SCROLL_GAP_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        chk("ctl_busy_after5", 32'(busy), 32'(exp_busy));
        wait_idle();

        // 6: async reset in column 3 then a clean restart
        send(7'h43);
        step();
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(col_valid), 32'd0);
        chk("arst_data", 32'(col_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(char_ready), 32'd1);
        q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle", 32'(col_valid), 32'd0);
        send(7'h44);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
